// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
//   state_t       : fetch sequencer states
//   fetch_entry_t : {pc, instr} pair at the default widths
//   DEF_*         : default widths and halt encoding
package ifu_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 32;
   localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Control, instruction-memory and decode-side signals of the fetch unit.
//   master : the fetch unit (drives imem_en/imem_addr, out_*, halted)
//   slave  : the surrounding core / memory / decode
interface ifu_if #(
   parameter int unsigned ADDR_W = ifu_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = ifu_pkg::DEF_DATA_W
);
   logic              start;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;

   modport master (
      input  start, redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_en, imem_addr, out_valid, out_instr, out_pc, halted
   );

   modport slave (
      output start, redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_en, imem_addr, out_valid, out_instr, out_pc, halted
   );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with flush; head is shown combinationally from storage.
//   clk, rst_n : clock, async active-low reset (storage cleared to 0)
//   push/push_data, pop : enqueue / dequeue; push while full is accepted if pop
//   flush      : empties the FIFO, dominates push/pop
//   head       : entry at the read pointer
//   count      : number of valid entries
module ifu_sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 48,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;

   // Pointer increment with wrap for non-power-of-two depths
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop_c  = pop && (count != '0);
   assign do_push_c = push && ((count != CNT_W'(DEPTH)) || do_pop_c);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push_c) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop_c) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC sequencer and instruction fetcher: issues word addresses to a 1-cycle
// instruction memory, buffers returned words with their PC and hands them to
// decode over valid/ready. Supports start, stall, redirect and halt-on-word.
//   clk, rst_n : clock, async active-low reset
//   bus        : ifu_if.master (start, redirect_*, imem_*, out_*, halted)
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W     = DEF_ADDR_W,
   parameter int unsigned       DATA_W     = DEF_DATA_W,
   parameter int unsigned       FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] START_PC   = '0,
   parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(DEF_HALT_WORD)
) (
   input  logic  clk,
   input  logic  rst_n,
   ifu_if.master bus
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              inflight, inflight_nxt;
   logic [ADDR_W-1:0] tag_pc, tag_nxt;
   logic              halted;

   logic [CNT_W-1:0]  count;
   entry_t            push_e;
   entry_t            head_e;
   logic              out_valid;
   logic              pop_c;
   logic              push_c;
   logic              issue_c;
   logic              halt_hit_c;
   logic [OCC_W-1:0]  occ_c;

   assign out_valid = (count != '0);
   assign pop_c     = out_valid && bus.out_ready;
   assign push_e    = '{pc: tag_pc, instr: bus.imem_rdata};

   // Output buffer; redirect flushes everything except a same-cycle handshake
   ifu_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (push_e),
      .pop       (pop_c),
      .flush     (bus.redirect_valid),
      .head      (head_e),
      .count     (count)
   );

   // State, PC and in-flight tag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= START_PC;
         inflight <= 1'b0;
         tag_pc   <= '0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         inflight <= inflight_nxt;
         tag_pc   <= tag_nxt;
         halted   <= (state_nxt == HALTED);
      end
   end

   // Next state, credit-based issue, return push and halt detection
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      inflight_nxt = 1'b0;
      tag_nxt      = tag_pc;
      issue_c      = 1'b0;
      push_c       = 1'b0;
      halt_hit_c   = 1'b0;
      // Slots already claimed after this cycle's pop
      occ_c        = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop_c);

      if (bus.redirect_valid) begin
         state_nxt = RUN;
         pc_nxt    = bus.redirect_pc;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (bus.start) state_nxt = RUN;
            end
            RUN: begin
               push_c     = inflight;
               halt_hit_c = inflight && (bus.imem_rdata == HALT_WORD);
               issue_c    = (occ_c < OCC_W'(FIFO_DEPTH));
               if (issue_c) begin
                  pc_nxt       = pc + ADDR_W'(1);
                  inflight_nxt = 1'b1;
                  tag_nxt      = pc;
               end
               // Drop any fetch issued alongside the halt word and rewind PC
               if (halt_hit_c) begin
                  state_nxt    = HALTED;
                  pc_nxt       = tag_pc + ADDR_W'(1);
                  inflight_nxt = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.imem_en   = issue_c;
   assign bus.imem_addr = pc;
   assign bus.out_valid = out_valid;
   assign bus.out_instr = head_e.instr;
   assign bus.out_pc    = head_e.pc;
   assign bus.halted    = halted;

endmodule
